uart_tx_fifo_top: RTL and testbench
===================================

// Module: uart_tx_fifo_top
// PURPOSE
//  Buffered UART transmitter: byte stream pushed at clock rate is stored in an on-chip FIFO and
//  serialised on `tx` as 8N1 frames, LSB first. Sits at the end of the image pipeline and
//  drains per-pixel bytes (e.g. Canny output) to the host link.
// PARAMETERS
//  CLK_FREQ    100_000_000  system clock frequency, Hz
//  BAUD        115_200      line rate; BIT_CYCLES = CLK_FREQ/BAUD (868 at defaults)
//  ADDR_W      10           FIFO address width; depth = 2**ADDR_W (1024 bytes)
// PORTS
//  clk           in   1  system clock, all logic on rising edge
//  reset         in   1  synchronous, active-low reset
//  tx_data       in   8  byte to enqueue
//  push          in   1  enqueue strobe, one byte per cycle while high
//  tx            out  1  serial line, idle high
//  tx_fifo_full  out  1  FIFO holds 2**ADDR_W bytes
// BEHAVIOUR
//  Reset (reset==0 at a rising edge): FIFO emptied (wr/rd ptr, count = 0), FSM -> IDLE, tx=1,
//   tx_fifo_full=0, bit/baud counters = 0. Reset mid-frame aborts the frame; tx=1 next cycle.
//  FIFO: synchronous RAM, write on push && !tx_fifo_full. Pointers wrap modulo depth.
//   tx_fifo_full = (count == 2**ADDR_W), derived from registered count (no comb path from push).
//   Push while full: byte dropped, no pointer/count change, stored data intact.
//   Simultaneous push+pop: both take effect, count unchanged; full is judged on the pre-edge
//   count, so a push while full is dropped even if a pop occurs in the same cycle.
//  TX FSM states: IDLE, LOAD, START, DATA, STOP.
//   IDLE : tx=1; if count!=0 assert pop (rd_ptr++, count--) -> LOAD.
//   LOAD : registered RAM read data captured into shift reg -> START (1 cycle).
//   START: tx=0 for BIT_CYCLES cycles -> DATA.
//   DATA : tx=shift[0] for BIT_CYCLES each; shift right; 8 bits -> STOP.
//   STOP : tx=1 for BIT_CYCLES -> IDLE.
//  Latency: first push at edge N -> tx falls at edge N+3 (count visible N+1, pop N+1, LOAD N+2).
//  Frame = 10*BIT_CYCLES cycles (8680 at defaults); consecutive queued bytes separated by exactly
//   2 extra idle-high cycles (IDLE+LOAD) after the stop bit.
//  tx is a registered output (glitch-free). Baud counter counts 0..BIT_CYCLES-1, restarts at every
//   state entry; BIT_CYCLES computed at elaboration, must be >= 2.
//  Bytes leave in push order; no byte emitted twice, none emitted that was dropped.
// STRUCTURE
//  uart_pkg: tx_state_e enum {IDLE,LOAD,START,DATA,STOP}, DATA_W=8, default CLK_FREQ/BAUD consts.
//  One sub-module: sync_fifo (RAM, pointers, count, full/empty); FSM + shifter in the top.
// TESTING
//  1 reset=0 for 5 cycles with push=1 -> tx=1, tx_fifo_full=0, nothing stored after release.
//  2 single push 0xA5 -> tx low 3 cycles later; bits 1,0,1,0,0,1,0,1 each 868 cycles; stop high.
//  3 push 0x00,0xFF,0x55 back-to-back -> three frames in order, 2-cycle idle gaps, count -> 0.
//  4 push every cycle 1100 cycles -> full asserts once count hits 1024; ~75 excess bytes dropped;
//    decoded output equals first pushed bytes (incl. one drained during fill) in order.
//  5 while full and a pop occurs, push new byte -> dropped; next cycle push -> accepted.
//  6 reset asserted mid DATA bit 4 -> tx=1 next cycle, FIFO empty, no further frames.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

  localparam int DATA_W       = 8;
  localparam int CLK_FREQ_DEF = 100_000_000;
  localparam int BAUD_DEF     = 115_200;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_e;

  // Clock cycles per serial bit. Ratios below 2 are raised to 2 because the
  // baud counter needs at least two distinct values.
  function automatic int bit_cycles(input int clk_freq, input int baud);
    int c;
    c = clk_freq / baud;
    return (c < 2) ? 2 : c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO: synchronous RAM with registered read port, wrapping
// pointers and an occupancy count from which full/empty are decoded.
module sync_fifo #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              push,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              wr_en;
  logic              rd_en;

  // Flags come from the registered count only, so push never feeds full combinationally.
  assign full  = (count == COUNT_FULL);
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array and registered read; data path is left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_ptr];
  end

endmodule

// File: rtl/uart_tx_fifo_top.sv
// Buffered 8N1 UART transmitter: bytes are queued in sync_fifo and shifted
// out LSB first on a registered, idle-high tx line.
module uart_tx_fifo_top
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD     = BAUD_DEF,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              push,
  output logic              tx,
  output logic              tx_fifo_full
);

  localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD);
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [2:0]       BIT_LAST  = 3'd7;

  tx_state_e         state;
  tx_state_e         state_next;
  logic              fifo_empty;
  logic              pop;
  logic              load_shift;
  logic              tx_d;
  logic              baud_done;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  baud_cnt;
  logic [2:0]        bit_idx;

  sync_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_data (tx_data),
    .push    (push),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (tx_fifo_full),
    .empty   (fifo_empty)
  );

  assign baud_done = (baud_cnt == BAUD_LAST);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic: each line state lasts one full bit period.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!fifo_empty) state_next = LOAD;
      LOAD:    state_next = START;
      START:   if (baud_done) state_next = DATA;
      DATA:    if (baud_done && bit_idx == BIT_LAST) state_next = STOP;
      STOP:    if (baud_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: pop request, shifter load, and the next line level.
  always_comb begin
    pop        = 1'b0;
    load_shift = 1'b0;
    tx_d       = 1'b1;
    unique case (state)
      IDLE:    pop = !fifo_empty;
      LOAD:    load_shift = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // Baud/bit counters and the tx flop; counters restart on every state entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
    end else begin
      tx <= tx_d;
      if (state == IDLE || state == LOAD || baud_done) baud_cnt <= '0;
      else                                            baud_cnt <= baud_cnt + 1'b1;
      if (state != DATA)  bit_idx <= '0;
      else if (baud_done) bit_idx <= bit_idx + 1'b1;
    end
  end

  // Shift register: loaded from the FIFO read port, shifted right after each data bit.
  always_ff @(posedge clk) begin
    if (load_shift)                     shift_q <= rd_data;
    else if (state == DATA && baud_done) shift_q <= {1'b0, shift_q[DATA_W-1:1]};
  end

endmodule

// File: tb/tb_uart_tx_fifo_top.sv
// Scoreboard bench for uart_tx_fifo_top with a short bit period and a
// 16-byte FIFO so every scenario completes in a few thousand cycles.
module tb_uart_tx_fifo_top;

  localparam int CLK_FREQ = 80;
  localparam int BAUD     = 10;
  localparam int BC       = CLK_FREQ / BAUD;
  localparam int ADDR_W   = 4;
  localparam int DEPTH    = 2 ** ADDR_W;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       push = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx;
  logic       tx_fifo_full;

  uart_tx_fifo_top #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_data      (tx_data),
    .push         (push),
    .tx           (tx),
    .tx_fifo_full (tx_fifo_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         fall;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_q[$];
  int         edge_cnt = 0;
  int         next_pop_ok = 0;
  int         last_rst_edge = -1;

  // Reference model: a byte queue plus a transmitter that is busy for
  // 10 bit periods + 2 cycles after taking a byte; tx falls 2 edges after it takes one.
  always @(posedge clk) begin
    bit   acc;
    bit   pp;
    exp_t e;
    edge_cnt++;
    if (!reset) begin
      model_q.delete();
      exp_q.delete();
      next_pop_ok   = edge_cnt + 1;
      last_rst_edge = edge_cnt;
    end else begin
      acc = push && (model_q.size() < DEPTH);
      pp  = (edge_cnt >= next_pop_ok) && (model_q.size() > 0);
      if (pp) begin
        e.data = model_q.pop_front();
        e.fall = edge_cnt + 2;
        exp_q.push_back(e);
        next_pop_ok = edge_cnt + 10 * BC + 2;
      end
      if (acc) model_q.push_back(tx_data);
    end
  end

  bit         in_frame = 1'b0;
  int         f_start = 0;
  logic [7:0] shreg = 8'h00;
  logic       prev_tx = 1'b1;

  // Monitor: decodes frames at mid-bit, checks full flag every cycle and tx after reset.
  always @(negedge clk) begin
    int   off;
    int   i;
    exp_t e;
    if (edge_cnt > 0) begin
      check("full_flag", tx_fifo_full, model_q.size() == DEPTH);
      if (last_rst_edge == edge_cnt) begin
        in_frame = 1'b0;
        check("tx_after_reset", tx, 1);
      end else if (!in_frame) begin
        if (prev_tx === 1'b1 && tx === 1'b0) begin
          in_frame = 1'b1;
          f_start  = edge_cnt;
        end
      end else begin
        off = edge_cnt - f_start;
        if (off >= BC / 2 && (off - BC / 2) % BC == 0) begin
          i = (off - BC / 2) / BC;
          if (i == 0) check("start_bit", tx, 0);
          else if (i <= 8) shreg[i-1] = tx;
          else begin
            check("stop_bit", tx, 1);
            in_frame = 1'b0;
            check("frame_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("frame_data", shreg, e.data);
              check("frame_fall_edge", f_start, e.fall);
            end
          end
        end
      end
      prev_tx = tx;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    push    = 1'b1;
    tx_data = d;
    idle(1);
    push    = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || model_q.size() != 0 || in_frame) && t < budget) begin
      idle(1);
      t++;
    end
    check(name, t < budget, 1);
    idle(4);
  endtask

  initial begin
    int t;

    // reset held with push active: nothing may be stored
    reset   = 1'b0;
    push    = 1'b1;
    tx_data = 8'h3C;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    push  = 1'b0;
    idle(30);
    check("t1_tx_idle", tx, 1);
    check("t1_not_full", tx_fifo_full, 0);

    // single byte
    push_byte(8'hA5);
    wait_drain("t2_drain", 400);

    // back-to-back bytes
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h55);
    wait_drain("t3_drain", 600);
    check("t3_not_full", tx_fifo_full, 0);

    // overfill with random bytes
    for (int k = 0; k < 40; k++) push_byte(8'($urandom));
    check("t4_full", tx_fifo_full, 1);

    // push on the cycle of a pop while full (dropped), then again (accepted)
    t = 0;
    while (edge_cnt + 1 != next_pop_ok && t < 200) begin
      idle(1);
      t++;
    end
    check("t5_pop_wait", t < 200, 1);
    push_byte(8'hE1);
    check("t5_after_drop_not_full", tx_fifo_full, 0);
    push_byte(8'h1E);
    check("t5_refilled_full", tx_fifo_full, 1);
    wait_drain("t4_t5_drain", 3000);

    // random traffic
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 2) == 0) push_byte(8'($urandom));
      else idle(1);
    end
    wait_drain("rand_drain", 20000);

    // reset in the middle of data bit 4
    push_byte(8'h96);
    push_byte(8'h69);
    t = 0;
    while (tx !== 1'b0 && t < 20) begin
      idle(1);
      t++;
    end
    check("t6_frame_started", t < 20, 1);
    idle(5 * BC + 2);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    check("t6_tx_high", tx, 1);
    check("t6_not_full", tx_fifo_full, 0);
    idle(300);
    check("t6_tx_still_idle", tx, 1);
    check("t6_no_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit at edge %0d", edge_cnt);
    $fatal(1, "timeout");
  end

endmodule
